// File: rtl/dmem_physical_ram.sv
// Byte-addressable data RAM with a fixed-latency strobe/complete handshake.
// Little-endian, wrapping accesses of 1/2/4/8 bytes; the top 4 GiB window decodes as IO.
module dmem_physical_ram #(
  parameter int    NUM_BYTES = 4096,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] addr,
  input  logic [1:0]  width,
  input  logic [63:0] data_in,
  input  logic        rstrobe,
  input  logic        wstrobe,
  output logic [63:0] data_out,
  output logic        io,
  output logic        busy,
  output logic        transaction_complete
);

  localparam int AW = $clog2(NUM_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            commit;

  logic [AW-1:0]   req_base_p0;
  logic [7:0]      req_be_p0;
  logic [63:0]     req_data_p0;
  logic            req_wr_p0;

  logic [7:0]      mem [NUM_BYTES];
  logic [AW-1:0]   byte_idx [8];
  logic [63:0]     rd_word;
  logic            unused_addr_bits;

  // Byte-enable pattern for each access size, lane 0 = lowest-addressed byte.
  function automatic logic [7:0] size_to_be(input logic [1:0] w);
    case (w)
      2'd0:    return 8'hFF;
      2'd1:    return 8'h0F;
      2'd2:    return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  assign io     = (addr[63:32] == 32'hFFFF_FFFF);
  assign accept = (rstrobe | wstrobe) & ~io & (state_q == ST_IDLE);
  assign commit = (state_q == ST_WAIT) && (cnt_q == '0);

  assign busy                 = (state_q != ST_IDLE);
  assign transaction_complete = (state_q == ST_DONE);

  // Address bits between the RAM index and the IO decode carry no meaning.
  assign unused_addr_bits = ^addr[31:AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = CW'(LATENCY - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---- stage p0: request captured at acceptance, held until completion ----
  always_ff @(posedge clk) begin
    if (accept) begin
      req_base_p0 <= addr[AW-1:0];
      req_be_p0   <= size_to_be(width);
      req_data_p0 <= data_in;
      req_wr_p0   <= wstrobe;
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      byte_idx[k] = req_base_p0 + AW'(k);
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 8; k++) begin
      if (req_be_p0[k]) begin
        rd_word[k*8 +: 8] = mem[byte_idx[k]];
      end
    end
  end

  // ---- commit: RAM update / read-data register, visible in the DONE cycle ----
  always_ff @(posedge clk) begin
    if (commit && req_wr_p0) begin
      for (int k = 0; k < 8; k++) begin
        if (req_be_p0[k]) begin
          mem[byte_idx[k]] <= req_data_p0[k*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (commit && !req_wr_p0) begin
      data_out <= rd_word;
    end
  end

endmodule

// File: tb/tb_dmem_physical_ram.sv
// Directed bench for dmem_physical_ram: vector table for the handshake and
// byte-lane behaviour, plus hand sequences for IO, busy, dual-strobe and reset abort.
module tb_dmem_physical_ram;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] addr;
   logic [1:0]  width;
   logic [63:0] data_in;
   logic        rstrobe;
   logic        wstrobe;
   logic [63:0] data_out;
   logic        io;
   logic        busy;
   logic        transaction_complete;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [63:0] a;
      logic [1:0]  w;
      logic [63:0] d;
      logic [63:0] exp;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   dmem_physical_ram #(.NUM_BYTES(4096), .LATENCY(2)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .addr                 (addr),
      .width                (width),
      .data_in              (data_in),
      .rstrobe              (rstrobe),
      .wstrobe              (wstrobe),
      .data_out             (data_out),
      .io                   (io),
      .busy                 (busy),
      .transaction_complete (transaction_complete)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   // Issue one strobe and wait for its completion pulse; returns cycles from the
   // accepting edge to the pulse, or -1 if none appeared within the budget.
   task automatic txn(input logic r, input logic w, input logic [63:0] a,
                      input logic [1:0] wd, input logic [63:0] d, output int lat);
      for (int c = 0; c < 20; c++) begin
         if (!busy) break;
         @(posedge clk); #1;
      end
      @(negedge clk);
      addr = a; width = wd; data_in = d; rstrobe = r; wstrobe = w;
      @(posedge clk); #1;
      rstrobe = 1'b0; wstrobe = 1'b0;
      addr = a + 64'h5; data_in = ~d; width = ~wd;
      lat = -1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (transaction_complete) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic count_pulses(input int cycles, output int n);
      n = 0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         if (transaction_complete) n++;
      end
   endtask

   initial begin
      int          lat;
      int          n;
      logic [63:0] last_rd;
      logic [63:0] exp;

      vecs[0]  = '{1'b0, 1'b1, 64'h10,  2'd0, 64'h0123456789ABCDEF, 64'h0};
      vecs[1]  = '{1'b1, 1'b0, 64'h10,  2'd0, 64'h0,                64'h0123456789ABCDEF};
      vecs[2]  = '{1'b0, 1'b1, 64'h13,  2'd3, 64'hFFFFFFFFFFFFFFAA, 64'h0};
      vecs[3]  = '{1'b0, 1'b1, 64'h14,  2'd2, 64'h111111111111BEEF, 64'h0};
      vecs[4]  = '{1'b1, 1'b0, 64'h10,  2'd0, 64'h0,                64'h0123BEEFAAABCDEF};
      vecs[5]  = '{1'b1, 1'b0, 64'h13,  2'd3, 64'h0,                64'h00000000000000AA};
      vecs[6]  = '{1'b1, 1'b0, 64'h12,  2'd1, 64'h0,                64'h00000000BEEFAAAB};
      vecs[7]  = '{1'b0, 1'b1, 64'hFFE, 2'd1, 64'h9999999911223344, 64'h0};
      vecs[8]  = '{1'b1, 1'b0, 64'hFFE, 2'd3, 64'h0,                64'h44};
      vecs[9]  = '{1'b1, 1'b0, 64'hFFF, 2'd3, 64'h0,                64'h33};
      vecs[10] = '{1'b1, 1'b0, 64'h000, 2'd3, 64'h0,                64'h22};
      vecs[11] = '{1'b1, 1'b0, 64'h001, 2'd3, 64'h0,                64'h11};
      vecs[12] = '{1'b1, 1'b0, 64'hFFE, 2'd2, 64'h0,                64'h3344};
      vecs[13] = '{1'b1, 1'b0, 64'h0000000100001FFF, 2'd3, 64'h0,   64'h33};
      vecs[14] = '{0, 1, 64'h20, 2'd0, 64'h0, 64'h0};
      vecs[15] = '{1'b0, 1'b1, 64'h21,  2'd2, 64'hFFFFFFFFFFFF1234, 64'h0};
      vecs[16] = '{1'b1, 1'b0, 64'h20,  2'd0, 64'h0,                64'h0000000000123400};
      vecs[17] = '{1'b1, 1'b0, 64'hFFE, 2'd1, 64'h0,                64'h11223344};

      rst = 1'b1; addr = '0; width = '0; data_in = '0; rstrobe = 1'b0; wstrobe = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_complete", {63'd0, transaction_complete}, 64'd0);
      chk("reset_data_out", data_out, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      last_rd = 64'h0;
      for (int i = 0; i < NV; i++) begin
         txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].w, vecs[i].d, lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
         if (vecs[i].rd && !vecs[i].wr) begin
            exp = vecs[i].exp;
            last_rd = exp;
         end else begin
            exp = last_rd;
         end
         chk($sformatf("vec%0d_data_out", i), data_out, exp);
      end
      @(posedge clk); #1;
      chk("complete_one_cycle", {63'd0, transaction_complete}, 64'd0);

      // IO decode and rejection of an IO-space write
      @(negedge clk);
      addr = 64'hFFFFFFFF_00000000; #1;
      chk("io_high", {63'd0, io}, 64'd1);
      addr = 64'hFFFFFFFE_00000000; #1;
      chk("io_low", {63'd0, io}, 64'd0);
      @(negedge clk);
      addr = 64'hFFFFFFFF_00000000; width = 2'd3; data_in = 64'h99; wstrobe = 1'b1;
      @(posedge clk); #1;
      wstrobe = 1'b0;
      chk("io_not_busy", {63'd0, busy}, 64'd0);
      count_pulses(5, n);
      chk("io_no_complete", 64'(n), 64'd0);
      txn(1'b1, 1'b0, 64'h0, 2'd3, 64'h0, lat);
      chk("io_ram_unchanged", data_out, 64'h22);

      // Second strobe while busy is dropped
      @(posedge clk); #1;
      @(negedge clk);
      addr = 64'h10; width = 2'd3; data_in = 64'h55; wstrobe = 1'b1;
      @(posedge clk); #1;
      wstrobe = 1'b0;
      chk("busy_after_accept", {63'd0, busy}, 64'd1);
      @(negedge clk);
      addr = 64'h11; width = 2'd3; data_in = 64'h66; wstrobe = 1'b1;
      @(posedge clk); #1;
      wstrobe = 1'b0;
      count_pulses(8, n);
      chk("busy_single_complete", 64'(n), 64'd1);
      txn(1'b1, 1'b0, 64'h11, 2'd3, 64'h0, lat);
      chk("busy_strobe_ignored", data_out, 64'hCD);
      txn(1'b1, 1'b0, 64'h10, 2'd3, 64'h0, lat);
      chk("busy_first_write", data_out, 64'h55);

      // Simultaneous strobes act as a write
      txn(1'b1, 1'b1, 64'h30, 2'd0, 64'hDEADBEEFCAFEF00D, lat);
      chk("dual_latency", 64'(lat), 64'd2);
      chk("dual_data_out_held", data_out, 64'h55);
      txn(1'b1, 1'b0, 64'h30, 2'd0, 64'h0, lat);
      chk("dual_wrote", data_out, 64'hDEADBEEFCAFEF00D);

      // Reset in WAIT aborts without a pulse; RAM contents survive
      @(posedge clk); #1;
      @(negedge clk);
      addr = 64'h10; width = 2'd3; rstrobe = 1'b1;
      @(posedge clk); #1;
      rstrobe = 1'b0;
      chk("abort_busy_before", {63'd0, busy}, 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_complete", {63'd0, transaction_complete}, 64'd0);
      chk("abort_data_out", data_out, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      count_pulses(5, n);
      chk("abort_no_complete", 64'(n), 64'd0);
      txn(1'b1, 1'b0, 64'h30, 2'd0, 64'h0, lat);
      chk("post_reset_latency", 64'(lat), 64'd2);
      chk("post_reset_contents", data_out, 64'hDEADBEEFCAFEF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
